result_collector: RTL and testbench
===================================

// Module: result_collector
// PURPOSE
//  Host-side receiver for the control unit's 8-byte result stream. Reassembles the byte sequence
//  c00[15:8],c00[7:0],c01[15:8],c01[7:0],c10[15:8],c10[7:0],c11[15:8],c11[7:0] into four signed
//  16-bit results. Completed frames go into a small frame FIFO and are released to the consumer
//  over a valid/ready handshake. Sits between the systolic array output path and the host bus.
// PARAMETERS
//  FIFO_DEPTH   2   completed frames buffered; power of 2, >= 2
//  CNT_W        8   width of frame_count
// PORTS
//  clk          in   1      single clock, all logic on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      in_data carries a result byte this cycle
//  in_sof       in   1      qualified by in_valid: this byte is byte 0 (c00[15:8]) of a frame
//  in_data      in   8      result byte
//  out_valid    out  1      head frame available on r00..r11
//  out_ready    in   1      consumer accepts head frame when out_valid && out_ready
//  r00,r01      out  16     signed head-frame results (row 0)
//  r10,r11      out  16     signed head-frame results (row 1)
//  frame_err    out  1      one-cycle pulse: partial frame discarded
//  overflow     out  1      sticky: completed frame dropped, FIFO full; cleared only by reset
//  frame_count  out  CNT_W  frames pushed into FIFO, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst_n low, async): FSM->IDLE, byte index=0, FIFO empty, out_valid=0, r*=0,
//   frame_err=0, overflow=0, frame_count=0. Reset mid-frame discards the partial frame silently.
//  FSM: IDLE, COLLECT.
//   IDLE: in_valid&&in_sof -> store byte 0, idx=1, go COLLECT. in_valid&&!in_sof -> byte dropped.
//   COLLECT: in_valid&&!in_sof -> store byte at idx (even idx = high byte, odd = low byte), idx++.
//    in_valid&&in_sof -> partial frame discarded, frame_err pulses next cycle, new frame starts
//    with this byte as byte 0 (stay COLLECT, idx=1).
//    Byte 7 accepted -> frame complete, push attempted on the same edge, go IDLE, idx=0.
//   in_valid low: hold state, no timeout.
//  Assembly: rXY = {high byte, low byte}, no sign extension or arithmetic; byte 7 written
//   directly into the FIFO entry (no staging cycle).
//  FIFO: circular, wr/rd pointers with one extra wrap bit; full = depth entries.
//   Push on completion if not full, or if full and a pop happens on the same edge (pop frees slot).
//   Push refused when full and no pop: frame dropped, overflow set, frame_count unchanged.
//   Successful push increments frame_count (wraps 2^CNT_W-1 -> 0).
//  Output: out_valid = FIFO not empty; r* driven registered from head entry; stable while
//   out_valid && !out_ready. Pop on out_valid&&out_ready; next entry (if any) presented next cycle.
//  Latency: byte 7 on edge N with FIFO empty -> out_valid=1 and r* valid after edge N.
//   Push and pop same edge on non-empty FIFO: occupancy unchanged.
//  out_valid never depends combinationally on out_ready.
// TESTING
//  1. Bytes 01,02,03,04,FF,FE,80,00 with sof on first, out_ready=1 -> one cycle after byte 7:
//     out_valid=1, r00=0x0102, r01=0x0304, r10=-2 (0xFFFE), r11=0x8000; frame_count=1.
//  2. Frame as test 1, second sof after 3 bytes then full frame of 0x11 bytes -> frame_err one
//     pulse; only frame r00..r11=0x1111 emitted; frame_count=1.
//  3. out_ready=0, push 3 complete frames (FIFO_DEPTH=2) -> first two retained in order,
//     overflow=1, frame_count=2; then out_ready=1 -> frames 1,2 drained, out_valid falls.
//  4. FIFO full, byte 7 of frame 3 arrives on same cycle as out_ready=1 -> frame 1 popped,
//     frame 3 pushed, overflow stays 0, frame_count=3.
//  5. rst_n low after 5 bytes, release, send full frame -> only new frame emitted, all outputs
//     were 0 during reset, no frame_err pulse.
//  6. Bytes without sof while IDLE, and in_valid gaps inside a frame -> stray bytes ignored;
//     gapped frame reassembled correctly.

Source files
------------

// File: rtl/result_collector.sv
// result_collector: reassembles the 8-byte result stream into four signed 16-bit
// results. Completed frames go through a small frame FIFO to a valid/ready consumer.
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_sof/in_data incoming result bytes; sof marks byte 0 (c00[15:8])
//   out_valid/out_ready     head-frame handshake
//   r00,r01,r10,r11         registered head-frame results
//   frame_err               one-cycle pulse when a partial frame is discarded
//   overflow                sticky: a completed frame was dropped because the FIFO was full
//   frame_count             frames pushed into the FIFO, wraps
module result_collector #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      r00,
    output logic [15:0]      r01,
    output logic [15:0]      r10,
    output logic [15:0]      r11,
    output logic             frame_err,
    output logic             overflow,
    output logic [CNT_W-1:0] frame_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned FW = 64;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0][7:0]  buf_q, buf_d;
    logic             complete_c;
    logic             frame_err_d;
    logic [FW-1:0]    frame_c;

    logic [FW-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             full_c, pop_c, push_c, drop_c;

    logic             out_valid_q, out_valid_d;
    logic [FW-1:0]    head_q, head_d;
    logic             frame_err_q;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Byte assembly FSM: byte index selects the buffer slot, byte 7 completes the frame
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        complete_c  = 1'b0;
        frame_err_d = 1'b0;
        if (in_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (in_sof) begin
                        buf_d[0] = in_data;
                        idx_d    = 3'd1;
                        state_d  = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (in_sof) begin
                        // restart: the new sof byte becomes byte 0 of a fresh frame
                        frame_err_d = 1'b1;
                        buf_d[0]    = in_data;
                        idx_d       = 3'd1;
                    end else begin
                        buf_d[idx_q] = in_data;
                        if (idx_q == 3'd7) begin
                            complete_c = 1'b1;
                            idx_d      = 3'd0;
                            state_d    = S_IDLE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    // Byte 7 goes straight into the FIFO entry via buf_d
    assign frame_c = {buf_d[0], buf_d[1], buf_d[2], buf_d[3],
                      buf_d[4], buf_d[5], buf_d[6], buf_d[7]};

    // FIFO control: a pop on the same edge frees the slot for a push into a full FIFO
    always_comb begin
        full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_c    = out_valid_q && out_ready;
        push_c   = complete_c && (!full_c || pop_c);
        drop_c   = complete_c && full_c && !pop_c;
        wr_ptr_d = wr_ptr_q + PW'(push_c);
        rd_ptr_d = rd_ptr_q + PW'(pop_c);
        cnt_d    = push_c ? cnt_q + CNT_W'(1) : cnt_q;
        overflow_d  = overflow_q | drop_c;
        out_valid_d = (wr_ptr_d != rd_ptr_d);
        // Next head: bypass the frame being written when it lands in the head slot
        if (!out_valid_d) begin
            head_d = head_q;
        end else if (push_c && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            head_d = frame_c;
        end else begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            buf_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            cnt_q       <= cnt_d;
        end
    end

    // Frame storage; contents are only read once the pointers mark them valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= frame_c;
        end
    end

    assign out_valid   = out_valid_q;
    assign r00         = head_q[63:48];
    assign r01         = head_q[47:32];
    assign r10         = head_q[31:16];
    assign r11         = head_q[15:0];
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;
    assign frame_count = cnt_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: frame reassembly, resync, FIFO overflow,
// simultaneous push/pop, reset mid-frame, stray bytes, gaps and counter wrap.
module tb_result_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r00, r01, r10, r11;
    logic        frame_err;
    logic        overflow;
    logic [7:0]  frame_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          err_cnt = 0;
    logic [63:0] got_q[$];

    result_collector #(.FIFO_DEPTH(2), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .r00         (r00),
        .r01         (r01),
        .r10         (r10),
        .r11         (r11),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge: frame_err pulses and every frame handed to the consumer
    always @(negedge clk) begin
        if (frame_err) err_cnt = err_cnt + 1;
        if (out_valid && out_ready) got_q.push_back({r00, r01, r10, r11});
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag, input int idx, input logic [63:0] exp);
        logic [63:0] g;
        g = (idx < got_q.size()) ? got_q[idx] : 64'hDEAD_DEAD_DEAD_DEAD;
        check(tag, g, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sof, input logic [7:0] d);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 0; i < 8; i++) send(i == 0, f[63-8*i -: 8]);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    localparam logic [63:0] T1 = 64'h0102_0304_FFFE_8000;
    localparam logic [63:0] T2 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] F1 = 64'h1001_1002_1003_1004;
    localparam logic [63:0] F2 = 64'h2001_2002_2003_2004;
    localparam logic [63:0] F3 = 64'h3001_3002_3003_3004;
    localparam logic [63:0] F4 = 64'h7F01_00FF_1234_ABCD;

    initial begin
        int gb;
        int eb;
        logic [63:0] f;

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_results", {r00, r01, r10, r11}, 64'd0);
        check("rst_flags", {62'd0, frame_err, overflow}, 64'd0);
        check("rst_count", 64'(frame_count), 64'd0);

        // 1: basic frame, one cycle latency after byte 7
        do_reset();
        out_ready = 1'b1;
        gb = got_q.size();
        send_frame(T1);
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_results", {r00, r01, r10, r11}, T1);
        check("t1_r10_neg2", 64'(r10), 64'h0000_0000_0000_FFFE);
        check("t1_count", 64'(frame_count), 64'd1);
        tick(); tick();
        check("t1_drained", 64'(out_valid), 64'd0);
        check("t1_nframes", 64'(got_q.size() - gb), 64'd1);

        // 2: sof mid-frame discards the partial frame
        do_reset();
        out_ready = 1'b1;
        gb = got_q.size();
        eb = err_cnt;
        send(1'b1, 8'h01); send(1'b0, 8'h02); send(1'b0, 8'h03);
        send(1'b1, 8'h11);
        check("t2_err_high", 64'(frame_err), 64'd1);
        send(1'b0, 8'h11);
        check("t2_err_low", 64'(frame_err), 64'd0);
        for (int i = 0; i < 6; i++) send(1'b0, 8'h11);
        tick(); tick();
        check("t2_err_pulses", 64'(err_cnt - eb), 64'd1);
        check("t2_nframes", 64'(got_q.size() - gb), 64'd1);
        check_frame("t2_frame", gb, T2);
        check("t2_count", 64'(frame_count), 64'd1);

        // 3: overflow with consumer stalled, then drain in order
        do_reset();
        gb = got_q.size();
        send_frame(F1);
        send_frame(F2);
        check("t3_full_count", 64'(frame_count), 64'd2);
        check("t3_no_ovf_yet", 64'(overflow), 64'd0);
        send_frame(F3);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_count", 64'(frame_count), 64'd2);
        check("t3_head_stable", {r00, r01, r10, r11}, F1);
        out_ready = 1'b1;
        repeat (4) tick();
        check("t3_drained", 64'(out_valid), 64'd0);
        check("t3_nframes", 64'(got_q.size() - gb), 64'd2);
        check_frame("t3_frame1", gb, F1);
        check_frame("t3_frame2", gb + 1, F2);
        check("t3_ovf_sticky", 64'(overflow), 64'd1);

        // 4: push into full FIFO on the same edge as a pop
        do_reset();
        gb = got_q.size();
        send_frame(F1);
        send_frame(F2);
        f = F3;
        for (int i = 0; i < 7; i++) send(i == 0, f[63-8*i -: 8]);
        out_ready = 1'b1;
        send(1'b0, f[7:0]);
        check("t4_no_overflow", 64'(overflow), 64'd0);
        check("t4_count", 64'(frame_count), 64'd3);
        check("t4_head", {r00, r01, r10, r11}, F2);
        repeat (4) tick();
        check("t4_drained", 64'(out_valid), 64'd0);
        check("t4_nframes", 64'(got_q.size() - gb), 64'd3);
        check_frame("t4_frame1", gb, F1);
        check_frame("t4_frame2", gb + 1, F2);
        check_frame("t4_frame3", gb + 2, F3);

        // 5: reset mid-frame with a frame already buffered
        do_reset();
        send_frame(F1);
        check("t5_pre_valid", 64'(out_valid), 64'd1);
        f = F2;
        for (int i = 0; i < 5; i++) send(i == 0, f[63-8*i -: 8]);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_results", {r00, r01, r10, r11}, 64'd0);
        check("t5_rst_count", 64'(frame_count), 64'd0);
        check("t5_rst_flags", {62'd0, frame_err, overflow}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        gb = got_q.size();
        eb = err_cnt;
        out_ready = 1'b1;
        send_frame(F3);
        tick(); tick();
        check("t5_nframes", 64'(got_q.size() - gb), 64'd1);
        check_frame("t5_frame", gb, F3);
        check("t5_no_err", 64'(err_cnt - eb), 64'd0);
        check("t5_count", 64'(frame_count), 64'd1);

        // 6: stray bytes while idle, gaps inside a frame
        do_reset();
        out_ready = 1'b1;
        gb = got_q.size();
        eb = err_cnt;
        send(1'b0, 8'h55);
        send(1'b0, 8'h66);
        check("t6_stray_count", 64'(frame_count), 64'd0);
        check("t6_stray_valid", 64'(out_valid), 64'd0);
        f = F4;
        for (int i = 0; i < 8; i++) begin
            send(i == 0, f[63-8*i -: 8]);
            if (i % 2 == 0) begin
                tick();
                tick();
            end
        end
        tick(); tick();
        check("t6_nframes", 64'(got_q.size() - gb), 64'd1);
        check_frame("t6_frame", gb, F4);
        check("t6_no_err", 64'(err_cnt - eb), 64'd0);
        check("t6_count", 64'(frame_count), 64'd1);

        // 7: frame_count wraps after 256 pushes
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            f = {8'(n), 56'h00_1122_3344_5566};
            send_frame(f);
        end
        tick();
        check("t7_wrap_count", 64'(frame_count), 64'd0);
        check("t7_wrap_no_ovf", 64'(overflow), 64'd0);
        send_frame(F1);
        check("t7_after_wrap", 64'(frame_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
